// File: rtl/pool_layer.sv
// pool_layer: 2x2 stride-2 signed max-pooling over conv feature maps in DRAM.
// Reads each window one word at a time, keeping only one read outstanding,
// and writes one pooled word per window to the destination region.
// Optional build macro: POOL_RELU_EN clamps negative pooled results to 0.
module pool_layer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int SRC_BASE   = 131072,
  parameter int DST_BASE   = 132672,
  parameter int MAP_W      = 10,
  parameter int MAP_H      = 10,
  parameter int NUM_CH     = 16
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  enable,
  input  logic                  dram_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_rd,
  output logic                  dram_en_wr,
  output logic                  done
);

  // Odd trailing row/column is dropped by the floor division.
  localparam int OH   = MAP_H / 2;
  localparam int OW   = MAP_W / 2;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int OH_W = (OH > 1) ? $clog2(OH) : 1;
  localparam int OW_W = (OW > 1) ? $clog2(OW) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [OH_W-1:0]       orow_q, orow_d;
  logic [OW_W-1:0]       ocol_q, ocol_d;
  logic [1:0]            k_q, k_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] addr_in_q, addr_in_d;
  logic [ADDR_WIDTH-1:0] addr_out_q, addr_out_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  // Working values for the WAIT/WR decisions.
  logic [DATA_WIDTH-1:0] new_max;
  logic                  last_col, last_row, last_ch;

  // Address of window element k (row-major within the 2x2 window).
  function automatic logic [ADDR_WIDTH-1:0] src_addr(
    input logic [CH_W-1:0] ch,
    input logic [OH_W-1:0] orow,
    input logic [OW_W-1:0] ocol,
    input logic [1:0]      k
  );
    return ADDR_WIDTH'(32'(SRC_BASE)
                       + 32'(ch) * 32'(MAP_H * MAP_W)
                       + (32'd2 * 32'(orow) + 32'(k[1])) * 32'(MAP_W)
                       + 32'd2 * 32'(ocol) + 32'(k[0]));
  endfunction

  // Address of the pooled output word for one window.
  function automatic logic [ADDR_WIDTH-1:0] dst_addr(
    input logic [CH_W-1:0] ch,
    input logic [OH_W-1:0] orow,
    input logic [OW_W-1:0] ocol
  );
    return ADDR_WIDTH'(32'(DST_BASE)
                       + 32'(ch) * 32'(OH * OW)
                       + 32'(orow) * 32'(OW)
                       + 32'(ocol));
  endfunction

  // Value actually written for a finished window.
  function automatic logic [DATA_WIDTH-1:0] out_value(input logic [DATA_WIDTH-1:0] m);
`ifdef POOL_RELU_EN
    return m[DATA_WIDTH-1] ? '0 : m;
`else
    return m;
`endif
  endfunction

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    orow_d     = orow_q;
    ocol_d     = ocol_q;
    k_d        = k_q;
    max_d      = max_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    done_d     = 1'b0;
    addr_in_d  = addr_in_q;
    addr_out_d = addr_out_q;
    data_out_d = data_out_q;

    // Strict greater-than keeps the earlier value on ties.
    if (k_q == 2'd0 || $signed(data_in) > $signed(max_q)) begin
      new_max = data_in;
    end else begin
      new_max = max_q;
    end

    last_col = (32'(ocol_q) == 32'(OW - 1));
    last_row = (32'(orow_q) == 32'(OH - 1));
    last_ch  = (32'(ch_q) == 32'(NUM_CH - 1));

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          ch_d      = '0;
          orow_d    = '0;
          ocol_d    = '0;
          k_d       = '0;
          state_d   = S_RD;
          rd_d      = 1'b1;
          addr_in_d = src_addr('0, '0, '0, 2'd0);
        end
      end
      S_RD: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dram_valid) begin
          max_d = new_max;
          if (k_q != 2'd3) begin
            k_d       = k_q + 2'd1;
            state_d   = S_RD;
            rd_d      = 1'b1;
            addr_in_d = src_addr(ch_q, orow_q, ocol_q, k_q + 2'd1);
          end else begin
            state_d    = S_WR;
            wr_d       = 1'b1;
            addr_out_d = dst_addr(ch_q, orow_q, ocol_q);
            data_out_d = out_value(new_max);
          end
        end
      end
      S_WR: begin
        k_d = 2'd0;
        if (last_col && last_row && last_ch) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          if (!last_col) begin
            ocol_d = ocol_q + 1'b1;
          end else begin
            ocol_d = '0;
            if (!last_row) begin
              orow_d = orow_q + 1'b1;
            end else begin
              orow_d = '0;
              ch_d   = ch_q + 1'b1;
            end
          end
          state_d   = S_RD;
          rd_d      = 1'b1;
          addr_in_d = src_addr(ch_d, orow_d, ocol_d, 2'd0);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset aborts any pass in flight.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      orow_q     <= '0;
      ocol_q     <= '0;
      k_q        <= '0;
      max_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
      addr_in_q  <= '0;
      addr_out_q <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      orow_q     <= orow_d;
      ocol_q     <= ocol_d;
      k_q        <= k_d;
      max_q      <= max_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      done_q     <= done_d;
      addr_in_q  <= addr_in_d;
      addr_out_q <= addr_out_d;
      data_out_q <= data_out_d;
    end
  end

  assign dram_en_rd = rd_q;
  assign dram_en_wr = wr_q;
  assign done       = done_q;
  assign addr_in    = addr_in_q;
  assign addr_out   = addr_out_q;
  assign data_out   = data_out_q;

endmodule

// File: tb/tb_pool_layer.sv
// Testbench for pool_layer: DRAM model with configurable read latency and a
// window-level reference model computed straight from the pooling rules.
module tb_pool_layer;

  localparam int DW       = 32;
  localparam int AW       = 18;
  localparam int SRC_BASE = 131072;
  localparam int DST_BASE = 132672;
  localparam int MW       = 10;
  localparam int MH       = 10;
  localparam int NCH      = 16;
  localparam int OHH      = MH / 2;
  localparam int OWW      = MW / 2;
  localparam int NOUT     = NCH * OHH * OWW;
  localparam int NSRC     = NCH * MH * MW;

  logic          clk = 1'b0;
  logic          srst;
  logic          enable;
  logic          dram_valid;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic [AW-1:0] addr_in;
  logic [AW-1:0] addr_out;
  logic          dram_en_rd;
  logic          dram_en_wr;
  logic          done;

  pool_layer dut (
    .clk        (clk),
    .srst       (srst),
    .enable     (enable),
    .dram_valid (dram_valid),
    .data_in    (data_in),
    .data_out   (data_out),
    .addr_in    (addr_in),
    .addr_out   (addr_out),
    .dram_en_rd (dram_en_rd),
    .dram_en_wr (dram_en_wr),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] src [NSRC];
  logic [AW-1:0] exp_ra[$];
  logic [AW-1:0] exp_wa[$];
  logic [DW-1:0] exp_wd[$];
  logic [AW-1:0] obs_wa[$];
  logic [DW-1:0] obs_wd[$];
  logic [AW-1:0] first_rd;

  // Reference model: for each window take the signed max of its four words.
  function automatic void build_model();
    int m, v;
    exp_ra.delete();
    exp_wa.delete();
    exp_wd.delete();
    for (int ch = 0; ch < NCH; ch++) begin
      for (int orow = 0; orow < OHH; orow++) begin
        for (int ocol = 0; ocol < OWW; ocol++) begin
          for (int k = 0; k < 4; k++) begin
            int idx;
            idx = ch * MH * MW + (2 * orow + k / 2) * MW + 2 * ocol + k % 2;
            exp_ra.push_back(AW'(SRC_BASE + idx));
            v = int'(src[idx]);
            if (k == 0 || v > m) m = v;
          end
`ifdef POOL_RELU_EN
          if (m < 0) m = 0;
`endif
          exp_wa.push_back(AW'(DST_BASE + ch * OHH * OWW + orow * OWW + ocol));
          exp_wd.push_back(DW'(m));
        end
      end
    end
  endfunction

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    int off;
    off = int'(a) - SRC_BASE;
    if (off >= 0 && off < NSRC) return src[off];
    return $urandom;
  endfunction

  // One full (or aborted) pass: starts with enable, serves reads with latency
  // lat, checks every strobe, and optionally pulses enable in WAIT or aborts.
  task automatic run_pass(input string name, input int lat, input bit glitch,
                          input int abort_after);
    int cyc, wcnt, rcnt, dcnt, cnt, last_wr_cyc, done_cyc, exp_total;
    bit pend, finished, glitched, aborted;
    logic [AW-1:0] paddr;
    build_model();
    obs_wa.delete();
    obs_wd.delete();
    cyc = 0; wcnt = 0; rcnt = 0; dcnt = 0; cnt = 0;
    last_wr_cyc = -1; done_cyc = -1;
    pend = 0; finished = 0; glitched = 0; aborted = 0;
    first_rd = '1;
    enable = 1'b1;
    dram_valid = 1'b0;
    while (!finished && !aborted && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      enable = 1'b0;
      dram_valid = 1'b0;
      data_in = $urandom;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          dram_valid = 1'b1;
          data_in = mem_read(paddr);
          pend = 0;
          if (glitch && !glitched && wcnt == 10) begin
            enable = 1'b1;
            glitched = 1;
          end
        end
      end
      if (dram_en_rd) begin
        n_vec++;
        if (pend || rcnt >= exp_ra.size() || addr_in !== exp_ra[rcnt]) begin
          n_err++;
          $display("FAIL %s read#%0d: got addr %0d outstanding=%0b expected addr %0d",
                   name, rcnt, addr_in, pend,
                   (rcnt < exp_ra.size()) ? int'(exp_ra[rcnt]) : -1);
        end
        if (rcnt == 0) first_rd = addr_in;
        pend = 1; cnt = lat; paddr = addr_in;
        rcnt++;
      end
      if (dram_en_wr) begin
        n_vec++;
        if (wcnt >= exp_wa.size() || addr_out !== exp_wa[wcnt] || data_out !== exp_wd[wcnt]) begin
          n_err++;
          $display("FAIL %s write#%0d: got addr %0d data %h expected addr %0d data %h",
                   name, wcnt, addr_out, data_out,
                   (wcnt < exp_wa.size()) ? int'(exp_wa[wcnt]) : -1,
                   (wcnt < exp_wd.size()) ? exp_wd[wcnt] : 32'hx);
        end
        obs_wa.push_back(addr_out);
        obs_wd.push_back(data_out);
        wcnt++;
        last_wr_cyc = cyc;
        if (abort_after > 0 && wcnt == abort_after) begin
          srst = 1'b1;
          aborted = 1;
        end
      end
      if (done) begin
        dcnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (dcnt > 0 && cyc >= done_cyc + 3) finished = 1;
    end

    if (aborted) begin
      @(posedge clk); #1;
      srst = 1'b0;
      dram_valid = 1'b0;
      n_vec++;
      if (dram_en_rd !== 1'b0 || dram_en_wr !== 1'b0 || done !== 1'b0 ||
          addr_in !== '0 || addr_out !== '0 || data_out !== '0) begin
        n_err++;
        $display("FAIL %s abort_outputs: got rd=%b wr=%b done=%b ain=%0d aout=%0d dout=%h expected all 0",
                 name, dram_en_rd, dram_en_wr, done, addr_in, addr_out, data_out);
      end
      for (int i = 0; i < 30; i++) begin
        @(posedge clk); #1;
        dram_valid = i[0];
        data_in = $urandom;
        n_vec++;
        if (dram_en_rd !== 1'b0 || dram_en_wr !== 1'b0 || done !== 1'b0) begin
          n_err++;
          $display("FAIL %s abort_quiet cyc%0d: got rd=%b wr=%b done=%b expected 0 0 0",
                   name, i, dram_en_rd, dram_en_wr, done);
        end
      end
      dram_valid = 1'b0;
      return;
    end

    exp_total = NOUT * (4 * (lat + 1) + 1) + 2;
    n_vec++;
    if (!finished) begin
      n_err++;
      $display("FAIL %s timeout: got no done within %0d cycles expected done", name, cyc);
    end
    n_vec++;
    if (wcnt != NOUT || rcnt != 4 * NOUT) begin
      n_err++;
      $display("FAIL %s counts: got %0d writes %0d reads expected %0d writes %0d reads",
               name, wcnt, rcnt, NOUT, 4 * NOUT);
    end
    n_vec++;
    if (dcnt != 1 || done_cyc != last_wr_cyc + 1) begin
      n_err++;
      $display("FAIL %s done: got %0d pulses at cycle %0d expected 1 pulse at cycle %0d",
               name, dcnt, done_cyc, last_wr_cyc + 1);
    end
    n_vec++;
    if (done_cyc + 1 != exp_total) begin
      n_err++;
      $display("FAIL %s total_cycles: got %0d expected %0d", name, done_cyc + 1, exp_total);
    end
    $display("pass %s L=%0d: %0d writes, %0d cycles", name, lat, wcnt, done_cyc + 1);
  endtask

  task automatic test_reset();
    srst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      enable = 1'($urandom);
      dram_valid = 1'($urandom);
      data_in = $urandom;
      @(posedge clk); #1;
      n_vec++;
      if (dram_en_rd !== 1'b0 || dram_en_wr !== 1'b0 || done !== 1'b0 ||
          addr_in !== '0 || addr_out !== '0 || data_out !== '0) begin
        n_err++;
        $display("FAIL reset_during cyc%0d: got rd=%b wr=%b done=%b ain=%0d aout=%0d dout=%h expected all 0",
                 i, dram_en_rd, dram_en_wr, done, addr_in, addr_out, data_out);
      end
    end
    srst = 1'b0;
    enable = 1'b0;
    dram_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (dram_en_rd !== 1'b0 || dram_en_wr !== 1'b0 || done !== 1'b0 ||
          addr_in !== '0 || addr_out !== '0 || data_out !== '0) begin
        n_err++;
        $display("FAIL reset_after cyc%0d: got rd=%b wr=%b done=%b ain=%0d aout=%0d dout=%h expected all 0",
                 i, dram_en_rd, dram_en_wr, done, addr_in, addr_out, data_out);
      end
    end
    $display("pass reset");
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NSRC; i++) src[i] = DW'(i);
  endtask

  task automatic test_ramp();
    fill_ramp();
    run_pass("ramp", 1, 0, 0);
    n_vec++;
    if (obs_wa.size() != NOUT) begin
      n_err++;
      $display("FAIL ramp_spot: got %0d writes expected %0d", obs_wa.size(), NOUT);
    end else begin
      if (obs_wa[0] !== AW'(132672) || obs_wd[0] !== 32'd11) begin
        n_err++;
        $display("FAIL ramp_first: got addr %0d data %0d expected addr 132672 data 11",
                 obs_wa[0], obs_wd[0]);
      end
      n_vec++;
      if (obs_wd[24] !== 32'd99) begin
        n_err++;
        $display("FAIL ramp_ch0_44: got %0d expected 99", obs_wd[24]);
      end
      n_vec++;
      if (obs_wa[NOUT-1] !== AW'(133071) || obs_wd[NOUT-1] !== 32'd1599) begin
        n_err++;
        $display("FAIL ramp_ch15_44: got addr %0d data %0d expected addr 133071 data 1599",
                 obs_wa[NOUT-1], obs_wd[NOUT-1]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < NSRC; i++) src[i] = $urandom;
    run_pass("random", int'($urandom_range(1, 3)), 0, 0);
  endtask

  task automatic test_negative();
    logic [DW-1:0] want;
    for (int i = 0; i < NSRC; i++) src[i] = -32'sd5;
`ifdef POOL_RELU_EN
    want = 32'd0;
`else
    want = -32'sd5;
`endif
    run_pass("negative", 1, 0, 0);
    n_vec++;
    if (obs_wd.size() == 0 || obs_wd[0] !== want || obs_wd[obs_wd.size()-1] !== want) begin
      n_err++;
      $display("FAIL negative_value: got %h expected %h",
               (obs_wd.size() > 0) ? obs_wd[0] : 32'hx, want);
    end
  endtask

  task automatic test_edge_values();
    logic [DW-1:0] want0, want1;
    for (int i = 0; i < NSRC; i++) src[i] = $urandom;
    // window (0,0): {-3, 7, -1, 7}; window (0,1): most-negative edge values
    src[0]  = -32'sd3;      src[1]  = 32'd7;
    src[10] = -32'sd1;      src[11] = 32'd7;
    src[2]  = 32'h80000000; src[3]  = 32'h80000001;
    src[12] = 32'h80000000; src[13] = 32'h80000000;
    want0 = 32'd7;
`ifdef POOL_RELU_EN
    want1 = 32'd0;
`else
    want1 = 32'h80000001;
`endif
    run_pass("edge", 2, 0, 0);
    n_vec++;
    if (obs_wd.size() < 2 || obs_wd[0] !== want0 || obs_wd[1] !== want1) begin
      n_err++;
      $display("FAIL edge_windows: got %h %h expected %h %h",
               (obs_wd.size() > 0) ? obs_wd[0] : 32'hx,
               (obs_wd.size() > 1) ? obs_wd[1] : 32'hx, want0, want1);
    end
  endtask

  task automatic test_enable_in_wait();
    fill_ramp();
    run_pass("enable_in_wait", 1, 1, 0);
  endtask

  task automatic test_abort_and_rerun();
    fill_ramp();
    run_pass("abort", 1, 0, 50);
    run_pass("rerun", 1, 0, 0);
    n_vec++;
    if (first_rd !== AW'(131072)) begin
      n_err++;
      $display("FAIL rerun_first_read: got %0d expected 131072", first_rd);
    end
  endtask

  task automatic test_latency();
    logic [AW-1:0] wa1[$];
    logic [DW-1:0] wd1[$];
    fill_ramp();
    run_pass("lat1", 1, 0, 0);
    wa1 = obs_wa;
    wd1 = obs_wd;
    run_pass("lat5", 5, 0, 0);
    n_vec++;
    if (wa1 != obs_wa || wd1 != obs_wd) begin
      n_err++;
      $display("FAIL latency_sequence: got %0d writes at L=5 differing from %0d writes at L=1 expected identical",
               obs_wa.size(), wa1.size());
    end
  endtask

  initial begin
    srst = 1'b1;
    enable = 1'b0;
    dram_valid = 1'b0;
    data_in = '0;
    test_reset();
    test_ramp();
    test_random();
    test_negative();
    test_edge_values();
    test_enable_in_wait();
    test_abort_and_rerun();
    test_latency();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
